record_engine: RTL

- Parametrised successor of the single-slot recorder. Captures audio samples from the audio interface and writes them to SDRAM starting at a latched base address, one decimated sample per word.
- Adds pause/resume, bounded length with auto-stop, decimation factor, overrun detection and a length header at the base word.
- Sits between the top-level controller and the shared SDRAM arbiter port.

---
 rtl/rec_pkg.sv | 42 ++++
 rtl/rec_sat_mix.sv | 28 ++
 rtl/record_engine.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rec_pkg.sv
// Shared types and helpers for the record engine: FSM state encoding, header
// offset and the per-channel saturating add used by the overdub mixer.
package rec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_HDR     = 3'd3,
        ST_RD      = 3'd4,
        ST_MIX     = 3'd5
    } rec_state_t;

    // Data words start one word past the header word.
    localparam int unsigned REC_HDR_OFFSET = 1;

    // Widest channel the saturating adder supports; narrower channels are
    // sign-extended into it and the result is truncated back by the caller.
    localparam int unsigned HALF_MAX_W = 32;
    localparam int unsigned SUM_W      = HALF_MAX_W + 1;

    // Signed add of two sign-extended channels, clamped to a w-bit signed range.
    function automatic logic signed [HALF_MAX_W-1:0] sat_add_half(
        input logic signed [HALF_MAX_W-1:0] a,
        input logic signed [HALF_MAX_W-1:0] b,
        input int unsigned                  w
    );
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        sum = {a[HALF_MAX_W-1], a} + {b[HALF_MAX_W-1], b};
        hi  = (SUM_W'(1) << (w - 1)) - SUM_W'(1);
        lo  = ~hi;
        if (sum > hi) begin
            return HALF_MAX_W'(hi);
        end else if (sum < lo) begin
            return HALF_MAX_W'(lo);
        end
        return HALF_MAX_W'(sum);
    endfunction

endpackage

// File: rtl/rec_sat_mix.sv
// Two-channel signed saturating mixer for overdub: each DATA_W/2 half of the
// new sample is added to the matching half of the old word and clamped.
// Only present when RECORD_OVERDUB_EN is defined.
`ifdef RECORD_OVERDUB_EN
module rec_sat_mix
    import rec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] mix_c
);

    localparam int unsigned HALF_W = DATA_W / 2;

    // Upper channel in the high half, lower channel in the low half.
    always_comb begin
        mix_c = {
            HALF_W'(sat_add_half(HALF_MAX_W'($signed(a[DATA_W-1:HALF_W])),
                                 HALF_MAX_W'($signed(b[DATA_W-1:HALF_W])), HALF_W)),
            HALF_W'(sat_add_half(HALF_MAX_W'($signed(a[HALF_W-1:0])),
                                 HALF_MAX_W'($signed(b[HALF_W-1:0])), HALF_W))
        };
    end

endmodule
`endif

// File: rtl/record_engine.sv
// Audio record engine: decimates incoming samples and stores them to SDRAM
// after a header word at a latched base address, with pause, bounded length,
// overrun flag and a final {overrun, length} header write.
// Optional overdub (read-mix-write) is enabled by defining RECORD_OVERDUB_EN.
module record_engine
    import rec_pkg::*;
#(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DECIM  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              rec_start,
    input  logic [ADDR_W-1:0] rec_base,
    input  logic [ADDR_W-1:0] rec_max_len,
    input  logic              rec_pause,
    input  logic              rec_stop,
    output logic              rec_busy,
    output logic              rec_done,
    output logic [ADDR_W-1:0] rec_len,
    output logic              rec_overrun,
    output logic              sd_read,
    output logic              sd_write,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_writedata,
    input  logic [DATA_W-1:0] sd_readdata,
    input  logic              sd_finished,
    output logic              aud_ready,
    input  logic [DATA_W-1:0] aud_data,
    input  logic              aud_valid
);

    localparam int unsigned       DCNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] HDR_OFF   = ADDR_W'(REC_HDR_OFFSET);

    rec_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] max_len_q, max_len_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              overrun_q, overrun_d;
    logic              stop_req_q, stop_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              sample_ok_c;
    logic [DATA_W-1:0] hdr_c;
    logic [ADDR_W-1:0] data_addr_c;

`ifdef RECORD_OVERDUB_EN
    logic [DATA_W-1:0] old_q, old_d;
    logic [DATA_W-1:0] mix_c;
    logic              read_q, read_d;

    rec_sat_mix #(
        .DATA_W(DATA_W)
    ) u_mix (
        .a     (sample_q),
        .b     (old_q),
        .mix_c (mix_c)
    );

    // Overdub read request and old-word registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            old_q  <= '0;
            read_q <= 1'b0;
        end else begin
            old_q  <= old_d;
            read_q <= read_d;
        end
    end

    assign sd_read = read_q;
`else
    logic rd_unused;
    assign rd_unused = ^sd_readdata;
    assign sd_read   = 1'b0;
`endif

    assign rec_busy     = busy_q;
    assign rec_done     = done_q;
    assign rec_len      = len_q;
    assign rec_overrun  = overrun_q;
    assign sd_write     = write_q;
    assign sd_addr      = addr_q;
    assign sd_writedata = wdata_q;
    assign aud_ready    = ready_q;

    // State, datapath and registered output flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            max_len_q  <= '0;
            len_q      <= '0;
            dcnt_q     <= '0;
            sample_q   <= '0;
            overrun_q  <= 1'b0;
            stop_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            max_len_q  <= max_len_d;
            len_q      <= len_d;
            dcnt_q     <= dcnt_d;
            sample_q   <= sample_d;
            overrun_q  <= overrun_d;
            stop_req_q <= stop_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they are
    // registered yet aligned with the state they describe.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        max_len_d   = max_len_q;
        len_d       = len_q;
        dcnt_d      = dcnt_q;
        sample_d    = sample_q;
        overrun_d   = overrun_q;
        stop_req_d  = stop_req_q;
        done_d      = 1'b0;
        sample_ok_c = aud_valid && !rec_pause;
`ifdef RECORD_OVERDUB_EN
        old_d       = old_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rec_start) begin
                    base_d     = rec_base;
                    max_len_d  = rec_max_len;
                    len_d      = '0;
                    dcnt_d     = '0;
                    overrun_d  = 1'b0;
                    stop_req_d = 1'b0;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Stop wins over a sample arriving in the same cycle.
                if (rec_stop || stop_req_q) begin
                    state_d = ST_HDR;
                end else if (sample_ok_c) begin
                    if (dcnt_q == DCNT_LAST) begin
                        sample_d = aud_data;
                        dcnt_d   = '0;
`ifdef RECORD_OVERDUB_EN
                        state_d  = ST_RD;
`else
                        state_d  = ST_WRITE;
`endif
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end
`ifdef RECORD_OVERDUB_EN
            ST_RD: begin
                if (sample_ok_c) overrun_d = 1'b1;
                if (rec_stop) stop_req_d = 1'b1;
                if (sd_finished) begin
                    old_d   = sd_readdata;
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                if (sample_ok_c) overrun_d = 1'b1;
                if (rec_stop) stop_req_d = 1'b1;
                sample_d = mix_c;
                state_d  = ST_WRITE;
            end
`endif
            ST_WRITE: begin
                if (sample_ok_c) overrun_d = 1'b1;
                if (rec_stop) stop_req_d = 1'b1;
                if (sd_finished) begin
                    len_d = len_q + ADDR_W'(1);
                    if (stop_req_q || rec_stop ||
                        ((max_len_q != '0) && (len_d == max_len_q))) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_HDR: begin
                if (sd_finished) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hdr_c              = DATA_W'(len_d);
        hdr_c[DATA_W-1]    = overrun_d;
        data_addr_c        = base_d + HDR_OFF + len_d;

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d != ST_IDLE) && (state_d != ST_HDR);
        write_d = (state_d == ST_WRITE) || (state_d == ST_HDR);
`ifdef RECORD_OVERDUB_EN
        read_d  = (state_d == ST_RD);
`endif

        if (state_d == ST_HDR) begin
            addr_d  = base_d;
            wdata_d = hdr_c;
        end else if (state_d == ST_WRITE) begin
            addr_d  = data_addr_c;
            wdata_d = sample_d;
`ifdef RECORD_OVERDUB_EN
        end else if (state_d == ST_RD) begin
            addr_d  = data_addr_c;
            wdata_d = '0;
`endif
        end else begin
            addr_d  = '0;
            wdata_d = '0;
        end
    end

endmodule
